apple_spawn_ctrl: RTL and testbench
===================================

APPLE_SPAWN_CTRL -- requirements
Module: apple_spawn_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_PROBES, default 256: maximum cells probed per spawn request; legal range 1..256.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port spawn_req, input, 1 bit: request to place a new apple.
REQ-005 The block SHALL have ports rand_x and rand_y, input, 4 bits each: random candidate row and column.
REQ-006 The block SHALL have ports RedPixels and GrnPixels, input, [15:0][15:0] each: playfield indexed [row][col].
REQ-007 The block SHALL have ports apple_x and apple_y, output, 4 bits each: placed apple row and column.
REQ-008 The block SHALL have port apple_valid, output, 1 bit: apple_x and apple_y hold a placed apple.
REQ-009 The block SHALL have port busy, output, 1 bit: a search is in progress.
REQ-010 The block SHALL have port spawn_done, output, 1 bit: one-cycle pulse when a request completes.
REQ-011 The block SHALL have port board_full, output, 1 bit: the last request found no free cell.

Function
REQ-012 The block SHALL implement FSM states IDLE, PROBE and FULL; busy SHALL be 1 exactly when the state is not IDLE.
REQ-013 In IDLE, when spawn_req=1 at a clock edge, the block SHALL load cursor={rand_x,rand_y}, clear probe_cnt, clear apple_valid and board_full, and enter PROBE.
REQ-014 spawn_req SHALL be ignored while busy=1; requests are not queued.
REQ-015 A cell SHALL be free when both RedPixels[row][col] and GrnPixels[row][col] are 0, evaluated on the current-cycle pixel values.
REQ-016 In PROBE, if the cursor cell is free, the block SHALL register apple_x=cursor row, apple_y=cursor col and apple_valid=1, pulse spawn_done for one cycle, and return to IDLE.
REQ-017 In PROBE, if the cursor cell is occupied, the block SHALL increment the 8-bit cursor by 1 and probe_cnt by 1.
REQ-018 The cursor increment SHALL advance the column first with carry into the row, and SHALL wrap from (15,15) to (0,0).
REQ-019 If the cursor cell is occupied and probe_cnt=MAX_PROBES-1, the block SHALL enter FULL instead of incrementing.
REQ-020 FULL SHALL last exactly one cycle and SHALL set board_full=1, pulse spawn_done, keep apple_valid=0, and return to IDLE.
REQ-021 board_full SHALL remain 1 until the next accepted spawn_req or reset.
REQ-022 Latency: a request whose candidate is free SHALL raise spawn_done in the second cycle after the request edge.
REQ-023 Each additional occupied cell probed SHALL add exactly one cycle to the latency in REQ-022.
REQ-024 apple_x, apple_y and apple_valid SHALL change only at the completion of a request (REQ-016) or at request acceptance (REQ-013, apple_valid cleared).

Reset
REQ-025 Asserting reset SHALL force the state to IDLE asynchronously, including in the middle of a search; any in-flight search SHALL be abandoned without a spawn_done pulse.
REQ-026 Reset values SHALL be: apple_x=12, apple_y=12, apple_valid=0, busy=0, spawn_done=0, board_full=0, cursor=0, probe_cnt=0.

Configuration
REQ-027 The macro APPLE_SPAWN_COUNT_EN SHALL control an optional spawn counter.
REQ-028 With APPLE_SPAWN_COUNT_EN defined, the block SHALL add output spawn_count, 8 bits, reset to 0, incremented by 1 on each successful placement (REQ-016) and saturating at 255.
REQ-029 Without APPLE_SPAWN_COUNT_EN, the spawn_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 The shared package snake_pkg SHALL hold the coord_t typedef (4 bits), the spawn_state_t enum, and the constants APPLE_RESET_X=12 and APPLE_RESET_Y=12.
REQ-031 The combinational occupancy lookup (pixel arrays plus row/col in, free flag out) SHALL be a sub-module named cell_lookup; the FSM and counters SHALL remain in apple_spawn_ctrl.

Verification
REQ-032 Scenario: reset mid-PROBE -> busy=0 immediately, apple=(12,12), apple_valid=0, no spawn_done pulse.
REQ-033 Scenario: empty board, request with rand=(5,6) -> spawn_done in the 2nd cycle after request, apple=(5,6), apple_valid=1.
REQ-034 Scenario: cells (3,14), (3,15) and (4,0) occupied, rand=(3,14) -> apple=(4,1), with latency 3 cycles longer than in REQ-033.
REQ-035 Scenario: only (15,15) occupied, rand=(15,15) -> cursor wraps and apple=(0,0).
REQ-036 Scenario: all 256 cells red, any rand, MAX_PROBES=256 -> board_full=1, apple_valid=0, one spawn_done pulse after 257 cycles; a later spawn_req clears board_full.
REQ-037 Scenario: spawn_req held high during a search -> a single completion, and a new search starts only on the first edge with the state back in IDLE.

Source files
------------

// File: rtl/apple_spawn_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// snake_pkg: definitions shared by the apple spawn controller, its bus
// interface and the occupancy lookup.
//   coord_t        - 4-bit playfield row/column index
//   spawn_state_t  - spawn controller FSM states
//   APPLE_RESET_X/Y - apple position held after reset
// ----------------------------------------------------------------------------
package snake_pkg;

    typedef logic [3:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        FULL  = 2'd2
    } spawn_state_t;

    localparam coord_t APPLE_RESET_X = 4'd12;
    localparam coord_t APPLE_RESET_Y = 4'd12;

endpackage

// File: rtl/apple_spawn_ctrl_if.sv
// ----------------------------------------------------------------------------
// apple_spawn_ctrl_if: request/result bus of the apple spawn controller.
//   spawn_req            - request to place a new apple
//   rand_x, rand_y       - random candidate row / column
//   RedPixels, GrnPixels - playfield occupancy, indexed [row][col]
//   apple_x, apple_y     - placed apple row / column
//   apple_valid          - apple_x/apple_y hold a placed apple
//   busy                 - a search is in progress
//   spawn_done           - one-cycle pulse when a request completes
//   board_full           - the last request found no free cell
//   spawn_count          - successful placements, saturating at 255
//                          (only when APPLE_SPAWN_COUNT_EN is defined)
// Modports: master drives requests (game logic), slave is the controller.
// ----------------------------------------------------------------------------
interface apple_spawn_ctrl_if;
    import snake_pkg::*;

    logic               spawn_req;
    coord_t             rand_x;
    coord_t             rand_y;
    logic [15:0][15:0]  RedPixels;
    logic [15:0][15:0]  GrnPixels;
    coord_t             apple_x;
    coord_t             apple_y;
    logic               apple_valid;
    logic               busy;
    logic               spawn_done;
    logic               board_full;
`ifdef APPLE_SPAWN_COUNT_EN
    logic [7:0]         spawn_count;

    modport master (
        output spawn_req, rand_x, rand_y, RedPixels, GrnPixels,
        input  apple_x, apple_y, apple_valid, busy, spawn_done, board_full, spawn_count
    );

    modport slave (
        input  spawn_req, rand_x, rand_y, RedPixels, GrnPixels,
        output apple_x, apple_y, apple_valid, busy, spawn_done, board_full, spawn_count
    );
`else
    modport master (
        output spawn_req, rand_x, rand_y, RedPixels, GrnPixels,
        input  apple_x, apple_y, apple_valid, busy, spawn_done, board_full
    );

    modport slave (
        input  spawn_req, rand_x, rand_y, RedPixels, GrnPixels,
        output apple_x, apple_y, apple_valid, busy, spawn_done, board_full
    );
`endif

endinterface

// File: rtl/apple_spawn_ctrl_cell_lookup.sv
// ----------------------------------------------------------------------------
// cell_lookup: combinational occupancy test for one playfield cell.
//   i_red, i_grn - playfield pixel planes, indexed [row][col]
//   i_row, i_col - cell to test
//   o_free       - 1 when neither plane lights the cell
// ----------------------------------------------------------------------------
module cell_lookup
    import snake_pkg::*;
(
    input  logic [15:0][15:0] i_red,
    input  logic [15:0][15:0] i_grn,
    input  coord_t            i_row,
    input  coord_t            i_col,
    output logic              o_free
);

    assign o_free = ~(i_red[i_row][i_col] | i_grn[i_row][i_col]);

endmodule

// File: rtl/apple_spawn_ctrl.sv
// ----------------------------------------------------------------------------
// apple_spawn_ctrl: finds a free playfield cell for a new apple.
// A request loads a cursor from the random candidate and walks the board
// (column first, carry into row, wrapping at (15,15)) one cell per cycle
// until a free cell is found or MAX_PROBES cells have been rejected.
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high reset
//   bus    - apple_spawn_ctrl_if.slave (request, playfield, results)
// Parameter MAX_PROBES (1..256): cells probed per request before giving up.
// Optional feature: define APPLE_SPAWN_COUNT_EN to add bus.spawn_count.
// ----------------------------------------------------------------------------
module apple_spawn_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned MAX_PROBES = 256
) (
    input  logic               clk,
    input  logic               reset,
    apple_spawn_ctrl_if.slave  bus
);

    localparam logic [7:0] LastProbe = 8'(MAX_PROBES - 1);

    spawn_state_t r_state;
    logic [7:0]   r_cursor;     // {row, col}; a plain +1 walks columns first
    logic [7:0]   r_probe_cnt;
    coord_t       r_apple_x;
    coord_t       r_apple_y;
    logic         r_apple_valid;
    logic         r_spawn_done;
    logic         r_board_full;
    logic         w_free;

    cell_lookup u_cell_lookup (
        .i_red  (bus.RedPixels),
        .i_grn  (bus.GrnPixels),
        .i_row  (r_cursor[7:4]),
        .i_col  (r_cursor[3:0]),
        .o_free (w_free)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cursor      <= 8'd0;
            r_probe_cnt   <= 8'd0;
            r_apple_x     <= APPLE_RESET_X;
            r_apple_y     <= APPLE_RESET_Y;
            r_apple_valid <= 1'b0;
            r_spawn_done  <= 1'b0;
            r_board_full  <= 1'b0;
        end else begin
            r_spawn_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.spawn_req) begin
                        r_cursor      <= {bus.rand_x, bus.rand_y};
                        r_probe_cnt   <= 8'd0;
                        r_apple_valid <= 1'b0;
                        r_board_full  <= 1'b0;
                        r_state       <= PROBE;
                    end
                end
                PROBE: begin
                    if (w_free) begin
                        r_apple_x     <= r_cursor[7:4];
                        r_apple_y     <= r_cursor[3:0];
                        r_apple_valid <= 1'b1;
                        r_spawn_done  <= 1'b1;
                        r_state       <= IDLE;
                    end else if (r_probe_cnt == LastProbe) begin
                        r_state <= FULL;
                    end else begin
                        r_cursor    <= r_cursor + 8'd1;
                        r_probe_cnt <= r_probe_cnt + 8'd1;
                    end
                end
                FULL: begin
                    r_board_full <= 1'b1;
                    r_spawn_done <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef APPLE_SPAWN_COUNT_EN
    logic [7:0] r_spawn_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_spawn_count <= 8'd0;
        end else if ((r_state == PROBE) && w_free && (r_spawn_count != 8'hFF)) begin
            r_spawn_count <= r_spawn_count + 8'd1;
        end
    end

    assign bus.spawn_count = r_spawn_count;
`endif

    assign bus.apple_x     = r_apple_x;
    assign bus.apple_y     = r_apple_y;
    assign bus.apple_valid = r_apple_valid;
    assign bus.spawn_done  = r_spawn_done;
    assign bus.board_full  = r_board_full;
    assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// ----------------------------------------------------------------------------
// tb_apple_spawn_ctrl: self-checking bench for apple_spawn_ctrl.
// A request-level model predicts every output each cycle; directed scenarios
// pin latency and placement with literal expectations.
// ----------------------------------------------------------------------------
module tb_apple_spawn_ctrl;
    import snake_pkg::*;

    localparam int unsigned MAXP = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;

    apple_spawn_ctrl_if bus();

    apple_spawn_ctrl #(.MAX_PROBES(MAXP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- request-level model ----------------
    bit         m_busy, m_done, m_valid, m_full, m_found;
    logic [3:0] m_ax = 4'd12, m_ay = 4'd12, m_rx, m_ry;
    int         m_remain;
    int         m_cnt;

    function automatic bit cell_free(input int r, input int c);
        return !(bus.RedPixels[r][c] || bus.GrnPixels[r][c]);
    endfunction

    // Whole search decided at acceptance: result cell and cycles until done.
    task automatic model_search(input int start);
        m_found = 0;
        m_remain = MAXP + 1;
        for (int k = 0; k < MAXP; k++) begin
            int idx;
            idx = (start + k) % 256;
            if (cell_free(idx / 16, idx % 16)) begin
                m_found = 1;
                m_remain = k + 1;
                m_rx = 4'(idx / 16);
                m_ry = 4'(idx % 16);
                break;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (reset) begin
            m_busy = 0; m_done = 0; m_valid = 0; m_full = 0;
            m_ax = 4'd12; m_ay = 4'd12; m_cnt = 0;
        end else if (!m_busy) begin
            m_done = 0;
            if (bus.spawn_req) begin
                model_search(int'(bus.rand_x) * 16 + int'(bus.rand_y));
                m_busy = 1; m_valid = 0; m_full = 0;
            end
        end else begin
            m_done = 0;
            m_remain--;
            if (m_remain == 0) begin
                m_busy = 0;
                m_done = 1;
                if (m_found) begin
                    m_ax = m_rx; m_ay = m_ry; m_valid = 1;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    m_full = 1;
                end
            end
        end
        chk("busy", bus.busy, m_busy);
        chk("spawn_done", bus.spawn_done, m_done);
        chk("apple_valid", bus.apple_valid, m_valid);
        chk("board_full", bus.board_full, m_full);
        chk("apple_x", bus.apple_x, m_ax);
        chk("apple_y", bus.apple_y, m_ay);
`ifdef APPLE_SPAWN_COUNT_EN
        chk("spawn_count", bus.spawn_count, m_cnt);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_board();
        bus.RedPixels = '0;
        bus.GrnPixels = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", bus.busy, 0);
    endtask

    // One request from idle; latency counted in negedges after the request edge.
    task automatic run_req(input string name, input int rx, input int ry, input int exp_lat,
                           input int ex, input int ey, input int exp_valid, input int exp_full);
        int c;
        @(negedge clk);
        bus.rand_x = 4'(rx);
        bus.rand_y = 4'(ry);
        bus.spawn_req = 1'b1;
        @(negedge clk);
        bus.spawn_req = 1'b0;
        c = 1;
        chk({name, "_accept_busy"}, bus.busy, 1);
        chk({name, "_accept_valid"}, bus.apple_valid, 0);
        chk({name, "_accept_full"}, bus.board_full, 0);
        while (!bus.spawn_done && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_latency"}, c, exp_lat);
        chk({name, "_valid"}, bus.apple_valid, exp_valid);
        chk({name, "_full"}, bus.board_full, exp_full);
        if (exp_valid != 0) begin
            chk({name, "_x"}, bus.apple_x, ex);
            chk({name, "_y"}, bus.apple_y, ey);
        end
        @(negedge clk);
        chk({name, "_pulse_len"}, bus.spawn_done, 0);
        chk({name, "_idle"}, bus.busy, 0);
    endtask

    task automatic rand_board();
        int mode;
        mode = $urandom_range(7, 0);
        if (mode == 7 && ($urandom % 4) != 0) mode = 5;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                bit occ, red;
                case (mode)
                    0:       occ = 0;
                    1, 2, 3: occ = ($urandom % 4) == 0;
                    7:       occ = 1;
                    default: occ = ($urandom % 16) != 0;
                endcase
                red = $urandom % 2;
                bus.RedPixels[r][c] = occ && red;
                bus.GrnPixels[r][c] = occ && (!red || ($urandom % 2) == 1);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int pulses, donec;
        bus.spawn_req = 1'b0;
        bus.rand_x = '0;
        bus.rand_y = '0;
        clear_board();
        repeat (2) @(negedge clk);
        chk("reset_x", bus.apple_x, 12);
        chk("reset_y", bus.apple_y, 12);
        chk("reset_busy", bus.busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // Empty board, candidate free.
        run_req("empty", 5, 6, 2, 5, 6, 1, 0);

        // Reset in the middle of a search.
        bus.RedPixels = '1;
        @(negedge clk);
        bus.rand_x = 4'd1; bus.rand_y = 4'd2; bus.spawn_req = 1'b1;
        @(negedge clk);
        bus.spawn_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_busy_before", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_x", bus.apple_x, 12);
        chk("midrst_y", bus.apple_y, 12);
        chk("midrst_valid", bus.apple_valid, 0);
        chk("midrst_done", bus.spawn_done, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.spawn_done) pulses++;
        end
        chk("midrst_no_done", pulses, 0);

        // Three occupied cells crossing a row boundary.
        clear_board();
        bus.RedPixels[3][14] = 1'b1;
        bus.GrnPixels[3][15] = 1'b1;
        bus.RedPixels[4][0]  = 1'b1;
        run_req("skip3", 3, 14, 5, 4, 1, 1, 0);

        // Wrap from (15,15) to (0,0).
        clear_board();
        bus.GrnPixels[15][15] = 1'b1;
        run_req("wrap", 15, 15, 3, 0, 0, 1, 0);

        // Full board.
        clear_board();
        bus.RedPixels = '1;
        run_req("full", $urandom_range(15, 0), $urandom_range(15, 0), 258, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        chk("full_sticky", bus.board_full, 1);
        clear_board();
        run_req("after_full", 9, 9, 2, 9, 9, 1, 0);

        // spawn_req held high across a search.
        clear_board();
        bus.RedPixels[3][14] = 1'b1;
        bus.RedPixels[3][15] = 1'b1;
        bus.GrnPixels[4][0]  = 1'b1;
        @(negedge clk);
        bus.rand_x = 4'd3; bus.rand_y = 4'd14; bus.spawn_req = 1'b1;
        pulses = 0;
        donec = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.rand_x = 4'd7; bus.rand_y = 4'd7;
            end
            if (bus.spawn_done) begin
                pulses++;
                donec = c;
            end
        end
        chk("hold_pulses", pulses, 1);
        chk("hold_done_cycle", donec, 5);
        chk("hold_first_x", bus.apple_x, 4);
        chk("hold_first_y", bus.apple_y, 1);
        @(negedge clk);
        bus.spawn_req = 1'b0;
        chk("hold_restart_busy", bus.busy, 1);
        @(negedge clk);
        chk("hold_second_done", bus.spawn_done, 1);
        chk("hold_second_x", bus.apple_x, 7);
        chk("hold_second_y", bus.apple_y, 7);

        // Randomised traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (reset) begin
                reset = 1'b0;
            end else if (($urandom % 500) == 0) begin
                reset = 1'b1;
            end
            if (!m_busy && ($urandom % 4) == 0) rand_board();
            bus.spawn_req = ($urandom % 3) != 0;
            bus.rand_x = 4'($urandom_range(15, 0));
            bus.rand_y = 4'($urandom_range(15, 0));
        end
        @(negedge clk);
        bus.spawn_req = 1'b0;
        reset = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
